// File: rtl/servo_slew_ctrl.sv
// Slew-rate limited position command stage feeding the servo PWM duty input.
// Optional input debounce is enabled by defining SERVO_SLEW_DEBOUNCE_EN.
module servo_slew_ctrl #(
    parameter int STEP_TICKS   = 50000,
    parameter int STEP_SIZE    = 4,
    parameter int STABLE_TICKS = 500000,
    parameter int POS_INIT     = 512
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [9:0] target,
    input  logic       hold,
    output logic [9:0] pos,
    output logic       pos_upd,
    output logic       busy,
    output logic       at_target
);

    localparam int             PW         = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(STEP_TICKS - 1);
    localparam logic [10:0]    STEP11     = 11'(STEP_SIZE);
    localparam logic [9:0]     INIT10     = 10'(POS_INIT);

    if (STEP_TICKS < 1 || STEP_SIZE < 1 || STEP_SIZE > 1023 || STABLE_TICKS < 1) begin : g_param_err
        $error("servo_slew_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } state_t;

    logic [9:0]    sync_p0;
    logic [9:0]    tsync;
    logic [9:0]    target_q;
    logic [PW-1:0] presc;
    state_t        state;
    state_t        state_nxt;

    // Up step, saturating at the accepted command (11-bit sum cannot wrap).
    function automatic logic [9:0] step_up(input logic [9:0] cur, input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, cur} + STEP11;
        return (sum > {1'b0, lim}) ? lim : sum[9:0];
    endfunction

    // Down step, saturating at the accepted command and never borrowing below 0.
    function automatic logic [9:0] step_dn(input logic [9:0] cur, input logic [9:0] lim);
        logic [10:0] diff;
        diff = {1'b0, cur} - STEP11;
        return (({1'b0, cur} < STEP11) || (diff[9:0] < lim)) ? lim : diff[9:0];
    endfunction

    // Stage p0: two-flop synchronizer on the raw command bus
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            sync_p0 <= INIT10;
            tsync   <= INIT10;
        end else begin
            sync_p0 <= target;
            tsync   <= sync_p0;
        end
    end

`ifdef SERVO_SLEW_DEBOUNCE_EN
    localparam int            DW          = ($clog2(STABLE_TICKS) > 20) ? $clog2(STABLE_TICKS) : 20;
    localparam logic [DW-1:0] STABLE_LAST = DW'(STABLE_TICKS - 1);

    logic [9:0]    tsync_prev;
    logic [DW-1:0] stable_cnt;

    // Stage p1: accept the command only after it has been steady long enough
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            tsync_prev <= INIT10;
            stable_cnt <= '0;
            target_q   <= INIT10;
        end else begin
            tsync_prev <= tsync;
            if (tsync != tsync_prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_LAST) begin
                stable_cnt <= stable_cnt + DW'(1);
            end else begin
                target_q <= tsync;
            end
        end
    end
`else
    // Stage p1: accepted command follows the synchronized input directly
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            target_q <= INIT10;
        end else begin
            target_q <= tsync;
        end
    end
`endif

    always_comb begin
        state_nxt = IDLE;
        if (pos < target_q) begin
            state_nxt = RAMP_UP;
        end else if (pos > target_q) begin
            state_nxt = RAMP_DN;
        end
    end

    // Stage p2: ramp state machine, prescaler and registered outputs
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state     <= IDLE;
            presc     <= '0;
            pos       <= INIT10;
            pos_upd   <= 1'b0;
            busy      <= 1'b0;
            at_target <= 1'b1;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            at_target <= (pos == target_q);
            pos_upd   <= 1'b0;
            if (state == IDLE) begin
                if (state_nxt != IDLE) begin
                    presc <= '0;
                end
            end else if (state_nxt != IDLE && !hold) begin
                // Direction comes from the live compare so a mid-ramp reversal never overshoots.
                if (presc == PRESC_LAST) begin
                    presc   <= '0;
                    pos_upd <= 1'b1;
                    pos     <= (state_nxt == RAMP_UP) ? step_up(pos, target_q)
                                                      : step_dn(pos, target_q);
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed bench for servo_slew_ctrl with STEP_TICKS=4, STEP_SIZE=4, STABLE_TICKS=8.
module tb_servo_slew_ctrl;

`ifdef SERVO_SLEW_DEBOUNCE_EN
    localparam int EXTRA = 8;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk;
    logic       rst_a;
    logic [9:0] target;
    logic       hold;
    logic [9:0] pos;
    logic       pos_upd;
    logic       busy;
    logic       at_target;

    int total = 0;
    int bad   = 0;

    servo_slew_ctrl #(
        .STEP_TICKS  (4),
        .STEP_SIZE   (4),
        .STABLE_TICKS(8),
        .POS_INIT    (512)
    ) dut (
        .clk      (clk),
        .rst_a    (rst_a),
        .target   (target),
        .hold     (hold),
        .pos      (pos),
        .pos_upd  (pos_upd),
        .busy     (busy),
        .at_target(at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] tgt;
        int         k;
        logic [9:0] pos;
        logic       upd;
        logic       busy;
        logic       at;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst_a  = 1'b1;
        hold   = 1'b0;
        target = 10'd512;
        tick();
        tick();
        rst_a = 1'b0;
    endtask

    task automatic wait_pos(input logic [9:0] v, input int maxc, input string name);
        for (int i = 0; i < maxc && pos != v; i++) tick();
        chk(name, pos, v);
    endtask

    // Full ramp from reset: every pulse must carry the modelled next position, 4 cycles apart.
    task automatic ramp_run(input logic [9:0] tgt, input string name);
        int prev, expv, npulse, last_k;
        do_reset();
        target = tgt;
        prev   = 512;
        npulse = 0;
        last_k = -1;
        for (int k = 1; k <= EXTRA + 530; k++) begin
            tick();
            if (pos_upd) begin
                npulse++;
                expv = (tgt > prev) ? ((prev + 4 > tgt) ? tgt : prev + 4)
                                    : ((prev - 4 < tgt) ? tgt : prev - 4);
                chk({name, "_step_pos"}, pos, expv);
                if (last_k >= 0) chk({name, "_spacing"}, k - last_k, 4);
                last_k = k;
            end else begin
                chk({name, "_no_pulse_hold"}, pos, prev);
            end
            prev = pos;
        end
        chk({name, "_pulses"}, npulse, 128);
        chk({name, "_final_pos"}, pos, tgt);
        chk({name, "_final_at"}, at_target, 1);
        chk({name, "_final_busy"}, busy, 0);
    endtask

    initial begin
        int cnt;
        int moved;

        vecs[0]  = '{10'd1023,   3, 10'd512,  1'b0, 1'b0, 1'b1};
        vecs[1]  = '{10'd1023,   4, 10'd512,  1'b0, 1'b1, 1'b0};
        vecs[2]  = '{10'd1023,   7, 10'd512,  1'b0, 1'b1, 1'b0};
        vecs[3]  = '{10'd1023,   8, 10'd516,  1'b1, 1'b1, 1'b0};
        vecs[4]  = '{10'd1023,   9, 10'd516,  1'b0, 1'b1, 1'b0};
        vecs[5]  = '{10'd1023,  12, 10'd520,  1'b1, 1'b1, 1'b0};
        vecs[6]  = '{10'd1023, 515, 10'd1020, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{10'd1023, 516, 10'd1023, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{10'd1023, 517, 10'd1023, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{10'd0,      8, 10'd508,  1'b1, 1'b1, 1'b0};
        vecs[10] = '{10'd0,    516, 10'd0,    1'b1, 1'b1, 1'b0};
        vecs[11] = '{10'd0,    517, 10'd0,    1'b0, 1'b0, 1'b1};
        vecs[12] = '{10'd514,    8, 10'd514,  1'b1, 1'b1, 1'b0};
        vecs[13] = '{10'd514,    9, 10'd514,  1'b0, 1'b0, 1'b1};
        vecs[14] = '{10'd512,   10, 10'd512,  1'b0, 1'b0, 1'b1};
        vecs[15] = '{10'd510,    8, 10'd510,  1'b1, 1'b1, 1'b0};

        // Reset values while asserted and after release
        rst_a  = 1'b1;
        hold   = 1'b0;
        target = 10'd512;
        tick();
        tick();
        chk("rst_on_pos", pos, 512);
        chk("rst_on_at", at_target, 1);
        chk("rst_on_busy", busy, 0);
        chk("rst_on_upd", pos_upd, 0);
        rst_a = 1'b0;
        tick();
        tick();
        chk("rst_off_pos", pos, 512);
        chk("rst_off_at", at_target, 1);
        chk("rst_off_busy", busy, 0);
        chk("rst_off_upd", pos_upd, 0);

        for (int i = 0; i < 16; i++) begin
            do_reset();
            target = vecs[i].tgt;
            repeat (EXTRA + vecs[i].k) tick();
            chk($sformatf("vec%0d_pos", i), pos, vecs[i].pos);
            chk($sformatf("vec%0d_upd", i), pos_upd, vecs[i].upd);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_at", i), at_target, vecs[i].at);
        end

        ramp_run(10'd1023, "up");
        ramp_run(10'd0, "dn");

        // Reversal: command drops to 590 just as pos reaches 600
        do_reset();
        target = 10'd1023;
        wait_pos(10'(600 - 4 * EXTRA / 4), EXTRA + 200, "rev_reach");
        target = 10'd590;
        repeat (EXTRA) tick();
        chk("rev_start_pos", pos, 600);
        repeat (4) tick();
        chk("rev_pos596", pos, 596);
        chk("rev_upd596", pos_upd, 1);
        repeat (4) tick();
        chk("rev_pos592", pos, 592);
        repeat (4) tick();
        chk("rev_pos590", pos, 590);
        chk("rev_busy_last", busy, 1);
        tick();
        chk("rev_busy_end", busy, 0);
        chk("rev_at_end", at_target, 1);

        // Hold mid-ramp with the prescaler frozen at 2
        do_reset();
        target = 10'd1023;
        wait_pos(10'd520, EXTRA + 40, "hold_reach");
        tick();
        tick();
        hold  = 1'b1;
        cnt   = 0;
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pos_upd) cnt++;
            if (pos != 10'd520) moved++;
        end
        chk("hold_pulses", cnt, 0);
        chk("hold_moved", moved, 0);
        chk("hold_busy", busy, 1);
        hold = 1'b0;
        tick();
        chk("hold_rel1_pos", pos, 520);
        chk("hold_rel1_upd", pos_upd, 0);
        tick();
        chk("hold_rel2_pos", pos, 524);
        chk("hold_rel2_upd", pos_upd, 1);

        // Asynchronous reset in the middle of an upward ramp
        do_reset();
        target = 10'd1023;
        wait_pos(10'd700, EXTRA + 300, "mid_reach");
        #2;
        rst_a = 1'b1;
        #1;
        chk("mid_rst_pos", pos, 512);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_upd", pos_upd, 0);
        chk("mid_rst_at", at_target, 1);
        tick();
        rst_a = 1'b0;

`ifdef SERVO_SLEW_DEBOUNCE_EN
        // Chattering input must never be accepted
        do_reset();
        moved = 0;
        for (int i = 0; i < 5; i++) begin
            target = (i % 2 == 0) ? 10'd100 : 10'd200;
            repeat (5) begin
                tick();
                if (busy || pos != 10'd512) moved++;
            end
        end
        chk("deb_chatter", moved, 0);
        target = 10'd200;
        repeat (11) tick();
        chk("deb_busy_before", busy, 0);
        tick();
        chk("deb_busy_after", busy, 1);
        chk("deb_at_after", at_target, 0);
        chk("deb_pos_after", pos, 512);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
